// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer sharing one enabled SR latch between NREQ requesters.
// Drives a setup / enable pulse / hold sequence and checks the latch readback.
module sr_latch_sequencer #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned EN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_op,
  input  logic            i_q_in,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_s_out,
  output logic            o_r_out,
  output logic            o_en_out,
  output logic            o_busy,
  output logic            o_err,
  output logic            o_q_exp
);

  localparam int unsigned IdxW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [IdxW-1:0]   r_ptr, w_ptr_d;
  logic [IdxW-1:0]   r_win, w_win_d;
  logic              r_op, w_op_d;
  logic [NREQ-1:0]   r_gnt, w_gnt_d;
  logic              r_s, w_s_d;
  logic              r_r, w_r_d;
  logic              r_en, w_en_d;
  logic              r_busy, w_busy_d;
  logic              r_err, w_err_d;
  logic              r_q_exp, w_q_exp_d;

  logic              w_found;
  logic [IdxW-1:0]   w_win;

  // Round-robin search starting at r_ptr, wrapping at NREQ-1.
  always_comb begin
    int unsigned v_idx;
    logic [IdxW-1:0] v_sel;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = (32'(r_ptr) + k) % NREQ;
      v_sel = IdxW'(v_idx);
      if (!w_found && i_req[v_sel]) begin
        w_found = 1'b1;
        w_win   = v_sel;
      end
    end
  end

  // Outputs are registered: each transition loads the values of the state being entered.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_ptr_d   = r_ptr;
    w_win_d   = r_win;
    w_op_d    = r_op;
    w_gnt_d   = '0;
    w_s_d     = r_s;
    w_r_d     = r_r;
    w_en_d    = r_en;
    w_busy_d  = r_busy;
    w_err_d   = r_err;
    w_q_exp_d = r_q_exp;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StSetup;
          w_win_d   = w_win;
          w_op_d    = i_op[w_win];
          w_s_d     = i_op[w_win];
          w_r_d     = ~i_op[w_win];
          w_en_d    = 1'b0;
          w_busy_d  = 1'b1;
        end
      end
      StSetup: begin
        w_state_d = StPulse;
        w_en_d    = 1'b1;
        w_cnt_d   = 4'(EN_CYCLES - 1);
      end
      StPulse: begin
        if (r_cnt == 4'd0) begin
          w_state_d      = StHold;
          w_en_d         = 1'b0;
          w_gnt_d[r_win] = 1'b1;
          w_q_exp_d      = r_op;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StHold: begin
        w_state_d = StIdle;
        w_s_d     = 1'b0;
        w_r_d     = 1'b0;
        w_busy_d  = 1'b0;
        w_ptr_d   = (r_win == IdxW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        if (i_q_in != r_op) begin
          w_err_d = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= 1'b0;
      r_gnt   <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_q_exp <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ptr   <= w_ptr_d;
      r_win   <= w_win_d;
      r_op    <= w_op_d;
      r_gnt   <= w_gnt_d;
      r_s     <= w_s_d;
      r_r     <= w_r_d;
      r_en    <= w_en_d;
      r_busy  <= w_busy_d;
      r_err   <= w_err_d;
      r_q_exp <= w_q_exp_d;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_s_out  = r_s;
  assign o_r_out  = r_r;
  assign o_en_out = r_en;
  assign o_busy   = r_busy;
  assign o_err    = r_err;
  assign o_q_exp  = r_q_exp;

endmodule
